// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the Ethernet receive path.
//   ETH_WORD_W  - payload word width produced by the RMII dibit aggregator
//   wfb_state_t - write-side frame FSM state of word_frame_buffer
package eth_pkg;

    localparam int ETH_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wfb_state_t;

endpackage

// File: rtl/frame_buffer_ram.sv
// frame_buffer_ram: simple dual-port RAM, one synchronous write port and one
// synchronous read port (read data valid one cycle after the address).
// A read and a write to the same address on one edge return the old contents.
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address (sampled on clk)
//   rdata  - registered read data
module frame_buffer_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/word_frame_buffer.sv
// word_frame_buffer: frame-aware FIFO between the RMII word aggregator and the
// packet parser. Words of a frame are stored speculatively and become visible
// to the reader only after frame_end commits them; a frame that overflows the
// buffer is rolled back as a whole and counted.
//   clk, rst          - clock, asynchronous active-high reset
//   axiiv/axiid       - input word valid / data
//   frame_end         - 1-cycle pulse closing the current frame
//   axior             - downstream ready
//   axiov/axiod/axiol - output valid / data / last-of-frame tag (registered)
//   drop_count        - saturating count of frames discarded on overflow
//   overflow          - 1-cycle pulse when a frame is dropped
module word_frame_buffer
    import eth_pkg::*;
#(
    parameter int DATA_W = ETH_WORD_W,
    parameter int DEPTH  = 512,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [DATA_W-1:0] axiid,
    input  logic              frame_end,
    input  logic              axior,
    output logic              axiov,
    output logic [DATA_W-1:0] axiod,
    output logic              axiol,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    wfb_state_t        state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d;
    logic              axiov_q, axiov_d;
    logic [DATA_W-1:0] axiod_q, axiod_d;
    logic              axiol_q, axiol_d;
    logic              byp_vld_q, byp_vld_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;

    logic              tag_q [DEPTH];
    logic              tag_we;
    logic [AW-1:0]     tag_addr;
    logic              tag_val;

    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_word;
    logic [AW-1:0]     wr_prev;
    logic              full;
    logic              avail;
    logic              load;

    assign full    = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign avail   = (rd_ptr_q != commit_ptr_q);
    assign wr_prev = wr_ptr_q[AW-1:0] - 1'b1;

    // The RAM is addressed with the next read pointer, so the word at rd_ptr_q
    // is already waiting when the output register loads. A word written on the
    // same edge as that prefetch is forwarded through the bypass register.
    assign rd_word = byp_vld_q ? byp_data_q : ram_rdata;

    frame_buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (axiid),
        .raddr (rd_ptr_d[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_count_d = drop_count_q;
        overflow_d   = 1'b0;
        ram_we       = 1'b0;
        tag_we       = 1'b0;
        tag_addr     = wr_ptr_q[AW-1:0];
        tag_val      = frame_end;

        unique case (state_q)
            IDLE, FILL: begin
                if (axiiv && full) begin
                    // Roll back to the frame start; a same-cycle frame_end
                    // closes the dropped frame immediately.
                    wr_ptr_d     = commit_ptr_q;
                    overflow_d   = 1'b1;
                    drop_count_d = sat_inc(drop_count_q);
                    state_d      = frame_end ? IDLE : DROP;
                end else if (axiiv) begin
                    ram_we   = 1'b1;
                    tag_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (frame_end) begin
                        commit_ptr_d = wr_ptr_q + 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d      = FILL;
                    end
                end else if (frame_end && state_q == FILL) begin
                    // Bare frame_end: retag the previously written word.
                    tag_we       = 1'b1;
                    tag_addr     = wr_prev;
                    tag_val      = 1'b1;
                    commit_ptr_d = wr_ptr_q;
                    state_d      = IDLE;
                end
            end
            DROP: begin
                if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load       = avail && (!axiov_q || axior);
        rd_ptr_d   = rd_ptr_q;
        axiov_d    = axiov_q;
        axiod_d    = axiod_q;
        axiol_d    = axiol_q;
        byp_vld_d  = ram_we && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
        byp_data_d = axiid;
        if (load) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            axiov_d   = 1'b1;
            axiod_d   = rd_word;
            axiol_d   = tag_q[rd_ptr_q[AW-1:0]];
            byp_vld_d = ram_we && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
        end else if (axior) begin
            axiov_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            axiov_q      <= 1'b0;
            axiod_q      <= '0;
            axiol_q      <= 1'b0;
            byp_vld_q    <= 1'b0;
            byp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            axiol_q      <= axiol_d;
            byp_vld_q    <= byp_vld_d;
            byp_data_q   <= byp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[tag_addr] <= tag_val;
        end
    end

    assign axiov      = axiov_q;
    assign axiod      = axiod_q;
    assign axiol      = axiol_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_word_frame_buffer.sv
module tb_word_frame_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              axiiv = 1'b0;
    logic [DATA_W-1:0] axiid = '0;
    logic              frame_end = 1'b0;
    logic              axior = 1'b0;
    logic              axiov;
    logic [DATA_W-1:0] axiod;
    logic              axiol;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    logic [32:0] exp_q [$];
    logic [32:0] pend_q [$];

    word_frame_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .axiiv      (axiiv),
        .axiid      (axiid),
        .frame_end  (frame_end),
        .axior      (axior),
        .axiov      (axiov),
        .axiod      (axiod),
        .axiol      (axiol),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every accepted beat must match the queue head.
    always @(negedge clk) begin
        if (!rst && axiov && axior) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=%0h required=none", {axiol, axiod});
            end else begin
                chk("beat", {31'd0, axiol, axiod}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic commit_pending();
        while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    endtask

    task automatic send(input logic [31:0] d, input logic fe, input logic keep);
        axiiv = 1'b1;
        axiid = d;
        frame_end = fe;
        if (keep) pend_q.push_back({fe, d});
        cyc();
        axiiv = 1'b0;
        frame_end = 1'b0;
        if (keep && fe) commit_pending();
    endtask

    task automatic end_frame(input logic keep);
        logic [32:0] t;
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        if (keep && pend_q.size() > 0) begin
            t = pend_q.pop_back();
            t[32] = 1'b1;
            pend_q.push_back(t);
            commit_pending();
        end
    endtask

    task automatic wait_valid(input int max, input string name);
        int n = 0;
        while (!axiov && n < max) begin
            cyc();
            n++;
        end
        chk(name, 64'(axiov), 64'd1);
    endtask

    task automatic burst(input int exp_len, input string name);
        int n = 0;
        while (axiov && n < 20) begin
            n++;
            cyc();
        end
        chk(name, 64'(n), 64'(exp_len));
    endtask

    task automatic async_reset(input string name);
        #2;
        rst = 1'b1;
        #1;
        chk({name, "_axiov"}, 64'(axiov), 64'd0);
        chk({name, "_axiod"}, 64'(axiod), 64'd0);
        chk({name, "_axiol"}, 64'(axiol), 64'd0);
        chk({name, "_drop"}, 64'(drop_count), 64'd0);
        chk({name, "_ovf"}, 64'(overflow), 64'd0);
        exp_q.delete();
        pend_q.delete();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        #1;
        rst = 1'b1;
        #1;
        chk("rst_axiov", 64'(axiov), 64'd0);
        chk("rst_axiod", 64'(axiod), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        // Four-word frame, bare frame_end, reader always ready.
        axior = 1'b1;
        send(32'hA0A0_0000, 1'b0, 1'b1); cyc();
        send(32'hA1A1_1111, 1'b0, 1'b1); cyc();
        send(32'hA2A2_2222, 1'b0, 1'b1); cyc();
        send(32'hA3A3_3333, 1'b0, 1'b1); cyc();
        end_frame(1'b1);
        chk("t1_lat_early", 64'(axiov), 64'd0);
        cyc();
        chk("t1_lat", 64'(axiov), 64'd1);
        burst(4, "t1_burst");
        repeat (3) cyc();

        // Reader stalled, then one ready pulse every sixth cycle.
        axior = 1'b0;
        send(32'hB0B0_0000, 1'b0, 1'b1); cyc();
        send(32'hB1B1_1111, 1'b0, 1'b1); cyc();
        send(32'hB2B2_2222, 1'b0, 1'b1); cyc();
        end_frame(1'b1);
        wait_valid(10, "t2_valid");
        repeat (3) cyc();
        chk("t2_hold_data", 64'(axiod), 64'hB0B0_0000);
        chk("t2_hold_last", 64'(axiol), 64'd0);
        for (int i = 0; i < 3; i++) begin
            axior = 1'b1;
            cyc();
            axior = 1'b0;
            repeat (5) cyc();
        end
        chk("t2_empty", 64'(axiov), 64'd0);

        // One-word frame, then a bare frame_end in IDLE.
        axior = 1'b1;
        send(32'hDEAD_BEEF, 1'b1, 1'b1);
        wait_valid(10, "t4_valid");
        chk("t4_last", 64'(axiol), 64'd1);
        burst(1, "t4_burst");
        end_frame(1'b0);
        repeat (6) cyc();
        chk("t4_bare", 64'(axiov), 64'd0);

        // Two frames back-to-back (3 + 2 words).
        fork
            begin
                send(32'hC0C0_0000, 1'b0, 1'b1);
                send(32'hC1C1_1111, 1'b0, 1'b1);
                send(32'hC2C2_2222, 1'b1, 1'b1);
                send(32'hD0D0_0000, 1'b0, 1'b1);
                send(32'hD1D1_1111, 1'b1, 1'b1);
            end
            begin
                wait_valid(20, "t6_valid");
                burst(5, "t6_burst");
            end
        join
        chk("t6_drop", 64'(drop_count), 64'd0);
        repeat (3) cyc();

        // Six-word frame overflows a four-entry buffer.
        for (int w = 0; w < 4; w++) begin
            send(32'hE000_0000 + 32'(w), 1'b0, 1'b0);
            cyc();
        end
        chk("t3_no_ovf", 64'(overflow), 64'd0);
        send(32'hE000_0004, 1'b0, 1'b0);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drop", 64'(drop_count), 64'd1);
        cyc();
        chk("t3_ovf_pulse", 64'(overflow), 64'd0);
        send(32'hE000_0005, 1'b0, 1'b0);
        end_frame(1'b0);
        repeat (6) cyc();
        chk("t3_nothing", 64'(axiov), 64'd0);
        send(32'hF0F0_0000, 1'b0, 1'b1); cyc();
        send(32'hF1F1_1111, 1'b1, 1'b1);
        wait_valid(10, "t3_next_valid");
        burst(2, "t3_next_burst");

        // Reset mid-frame, then while a word is held un-accepted.
        send(32'h6060_0000, 1'b0, 1'b1); cyc();
        send(32'h6161_1111, 1'b0, 1'b1);
        async_reset("t5a");
        axior = 1'b0;
        send(32'h7070_0000, 1'b0, 1'b1); cyc();
        send(32'h7171_1111, 1'b1, 1'b1);
        wait_valid(10, "t5_pre_valid");
        async_reset("t5b");
        repeat (4) cyc();
        chk("t5_quiet", 64'(axiov), 64'd0);
        axior = 1'b1;
        send(32'h8080_0000, 1'b0, 1'b1); cyc();
        send(32'h8181_1111, 1'b0, 1'b1); cyc();
        send(32'h8282_2222, 1'b1, 1'b1);
        wait_valid(10, "t5_post_valid");
        burst(3, "t5_post_burst");

        // Four overflowing frames: the 2-bit counter saturates at 3.
        for (int k = 1; k <= 4; k++) begin
            for (int w = 0; w < 5; w++) begin
                send(32'h9000_0000 + 32'(k * 16 + w), 1'b0, 1'b0);
                if (w == 4) chk("sat_ovf", 64'(overflow), 64'd1);
            end
            end_frame(1'b0);
            chk("sat_drop", 64'(drop_count), 64'((k < 3) ? k : 3));
        end
        repeat (6) cyc();
        chk("sat_nothing", 64'(axiov), 64'd0);

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) cyc();
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
